risc_sequencer: RTL
===================

# risc_sequencer

Control sequencer for the 3-bit-opcode accumulator CPU. It steps an 8-phase instruction cycle and consumes the `opcode_t` value held in the instruction register. From the current phase, opcode and ALU zero flag it drives the memory, IR, PC and accumulator strobes. It also tracks a sticky halt condition and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ena`  in  1: phase advance enable; 0 holds all state.
- `opcode`  in  `opcode_t` (3): instruction register opcode; valid from phase IDLE onward.
- `zero`  in  1: accumulator-is-zero flag from the ALU.
- `mem_rd`  out  1: memory read strobe.
- `mem_wr`  out  1: memory write strobe.
- `load_ir`  out  1: instruction register load.
- `inc_pc`  out  1: program counter increment.
- `load_pc`  out  1: program counter load (jump).
- `load_ac`  out  1: accumulator load.
- `halt`  out  1: halt indication.
- `phase`  out  `state_t` (3): current phase.
- `instr_cnt`  out  `CNT_W`: retired instruction count.

## Operation
- Phases cycle in order: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → INST_ADDR.
- `aluop` = opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes are combinational decode of registered `phase`, `opcode`, `zero` and `halted`. Any strobe not listed for a phase is 0.
  - INST_ADDR: all strobes 0.
  - INST_FETCH: `mem_rd`=1.
  - INST_LOAD: `mem_rd`=1, `load_ir`=1.
  - IDLE: `mem_rd`=1, `load_ir`=1.
  - OP_ADDR: `halt`=(opcode==HLT); `inc_pc`=(opcode!=HLT).
  - OP_FETCH: `mem_rd`=`aluop`.
  - ALU_OP: `mem_rd`=`aluop`, `load_ac`=`aluop`, `inc_pc`=(opcode==SKZ && `zero`), `load_pc`=(opcode==JMP).
  - STORE: `mem_rd`=`aluop`, `load_ac`=`aluop`, `inc_pc`=(opcode==JMP), `load_pc`=(opcode==JMP), `mem_wr`=(opcode==STO).
- Halt behaviour:
  - If phase is OP_ADDR, opcode is HLT and `ena`=1, the internal `halted` flag sets at the edge and the phase freezes in OP_ADDR.
  - While `halted`=1: `halt`=1 and every other strobe is 0, regardless of opcode or `ena`.
  - Only `rst` clears `halted`.
- Instruction counter:
  - `instr_cnt` increments on each STORE→INST_ADDR transition.
  - It wraps modulo 2^CNT_W with no saturation and no flag.
  - HLT never reaches STORE and is not counted.
- `ena`=0 holds `phase`, `halted` and `instr_cnt`. Strobes keep decoding the held phase; downstream qualifies them with `ena`.

## Timing
- Reset values: `phase`=INST_ADDR, `halted`=0, `instr_cnt`=0. All strobes therefore read 0 after reset.
- `rst` has priority over `ena`. Asserting reset mid-instruction returns `phase` to INST_ADDR at the next edge and discards the in-flight instruction, which is not counted.
- With `ena` held at 1, one instruction takes exactly 8 cycles. `instr_cnt` updates on the edge that ends STORE.
- Strobes are valid in the same cycle as `phase` (zero-latency decode). `opcode` and `zero` must be stable before the rising edge.
- `ena` dropped in any phase stalls the machine exactly one phase per low cycle. No phase is skipped or repeated when `ena` returns high.
- A simultaneous HLT in OP_ADDR and `ena`=0 does not set `halted`; `halt` is still 1 combinationally in that cycle.

## Structure
- Add `typedef enum logic [2:0] state_t` to the shared `typedefs_v2` package, with the phase encodings above, alongside `opcode_t`.
- Single module: one `always_ff` for phase, `halted` and counter; one `always_comb` for the strobe decode.
- No sub-module is warranted.

## Test plan
- Reset: assert `rst` for 2 cycles with `ena`=1 → `phase`=0, all strobes 0, `instr_cnt`=0.
- ADD with `ena`=1 for 8 cycles:
  - `mem_rd` high in phases 1–3 and 5–7.
  - `load_ir` high in phases 2–3.
  - `inc_pc` high in phase 4.
  - `load_ac` high in phases 6–7.
  - `instr_cnt` 0→1 after STORE.
- SKZ, run twice:
  - `zero`=1 → `inc_pc`=1 in ALU_OP.
  - `zero`=0 → `inc_pc`=0 in ALU_OP.
  - No `load_ac` in either run.
- JMP → `load_pc`=1 in phases 6 and 7, `inc_pc`=1 in phase 7. STO → `mem_wr`=1 only in phase 7.
- HLT:
  - `halt`=1 at phase 4, `inc_pc`=0.
  - `phase` holds 4 for 20 further cycles with `ena`=1.
  - `instr_cnt` unchanged.
  - `rst` → `phase`=0, `halt`=0.
- Stall and reset:
  - `ena`=0 for 3 cycles in OP_FETCH → `phase` stays 5, then continues to 6.
  - `rst` in ALU_OP → `phase`=0 next cycle, `instr_cnt` not incremented.
  - With `CNT_W`=4, 16 instructions → `instr_cnt` wraps to 0.

Source files
------------

// File: rtl/typedefs_v2.sv
// Shared types for the 3-bit-opcode accumulator CPU: opcode and sequencer phase encodings.
package typedefs_v2;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

endpackage

// File: rtl/risc_sequencer.sv
// 8-phase control sequencer: steps the instruction cycle, decodes strobes,
// holds a sticky halt and counts retired instructions.
module risc_sequencer
    import typedefs_v2::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  opcode_t          opcode,
    input  logic             zero,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ac,
    output logic             halt,
    output state_t           phase,
    output logic [CNT_W-1:0] instr_cnt
);

    logic halted;
    logic aluop;

    assign aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= INST_ADDR;
            halted    <= 1'b0;
            instr_cnt <= '0;
        end else if (ena && !halted) begin
            // HLT freezes the machine in OP_ADDR; it never reaches STORE so is not counted
            if (phase == OP_ADDR && opcode == HLT) begin
                halted <= 1'b1;
            end else begin
                phase <= state_t'(phase + 3'd1);
                if (phase == STORE)
                    instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        halt    = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    halt   = (opcode == HLT);
                    inc_pc = (opcode != HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

endmodule
